// File: rtl/shared_out_arbiter_pkg.sv
// Shared types and decode helper for the shared-output arbiter and related blocks.
package shared_out_arbiter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CODE_CLR  = 2'b00,
        CODE_SET  = 2'b01,
        CODE_HOLD = 2'b10,
        CODE_TOG  = 2'b11
    } code_e;

    // Next value of the shared output for a winner's command code.
    function automatic logic decode_out(input logic [1:0] code, input logic cur);
        logic nxt;
        nxt = cur;
        case (code)
            CODE_CLR:  nxt = 1'b0;
            CODE_SET:  nxt = 1'b1;
            CODE_HOLD: nxt = cur;
            CODE_TOG:  nxt = ~cur;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/shared_out_arbiter_if.sv
// Requester-side bundle of the shared-output arbiter: requests and codes in,
// grant and the shared output back.
interface shared_out_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int CODE_W = 2
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*CODE_W-1:0] code;
    logic [N_REQ-1:0]        grant;
    logic                    out;
    logic                    out_valid;
    logic                    busy;

    modport master (output req, code, input grant, out, out_valid, busy);
    modport slave  (input req, code, output grant, out, out_valid, busy);
endinterface

// File: rtl/shared_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves a latch.
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                pick[cand] = 1'b1;
            end
            cand = (cand == IDX_W'(N_REQ - 1)) ? '0 : cand + IDX_W'(1);
        end
    end

endmodule

// File: rtl/shared_out_arbiter.sv
// Round-robin arbiter granting one requester at a time the shared registered
// output `out` for HOLD cycles; the winner's code is decoded once on entry.
module shared_out_arbiter
    import shared_out_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int CODE_W = 2,
    parameter int HOLD   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    shared_out_arbiter_if.slave bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0]  pick;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [CODE_W-1:0] code_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_code
        assign code_arr[g] = bus.code[g*CODE_W +: CODE_W];
    end

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                grant_d     = '0;
                out_valid_d = 1'b0;
                if (pick_any) begin
                    state_d     = ST_DRIVE;
                    grant_d     = pick;
                    win_d       = pick_idx;
                    // The winner's code is consumed here; later code changes cannot reach `out`.
                    out_d       = decode_out(code_arr[pick_idx], out_q);
                    out_valid_d = 1'b1;
                    cnt_d       = CNT_W'(HOLD - 1);
                end
            end
            ST_DRIVE: begin
                if (!bus.req[win_q] || cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                    out_valid_d = 1'b0;
                    ptr_d       = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_d     = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: reset is sampled on the clock edge, so it also overrides any request present that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking updates keep every flop reading pre-edge values of the others.
            state_q     <= state_d;
            grant_q     <= grant_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == ST_DRIVE);

endmodule

// File: tb/tb_shared_out_arbiter.sv
// Bench for shared_out_arbiter: two instances (HOLD=3 and HOLD=1), directed
// scenarios with literal expectations plus randomized traffic against a grant-level model.
module tb_shared_out_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    shared_out_arbiter_if #(.N_REQ(4), .CODE_W(2)) if0 ();
    shared_out_arbiter_if #(.N_REQ(4), .CODE_W(2)) if1 ();

    shared_out_arbiter #(.N_REQ(4), .CODE_W(2), .HOLD(3)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    shared_out_arbiter #(.N_REQ(4), .CODE_W(2), .HOLD(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Grant-level model: who owns the output, how many grant cycles remain, where the search starts.
    int   hold_of [2] = '{3, 1};
    bit   m_act   [2];
    int   m_w     [2];
    int   m_left  [2];
    int   m_ptr   [2];
    logic m_out   [2];

    task automatic model_step(input int m, input logic rst, input logic [3:0] r, input logic [7:0] c);
        int   w;
        bit   found;
        logic [1:0] cc;
        if (!rst) begin
            m_act[m]  = 1'b0;
            m_w[m]    = 0;
            m_left[m] = 0;
            m_ptr[m]  = 0;
            m_out[m]  = 1'b0;
        end else if (!m_act[m]) begin
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(m_ptr[m] + k) % 4]) begin
                    found = 1'b1;
                    w     = (m_ptr[m] + k) % 4;
                end
            end
            if (found) begin
                m_act[m]  = 1'b1;
                m_w[m]    = w;
                m_left[m] = hold_of[m];
                cc        = c[2*w +: 2];
                if (cc == 2'd0)      m_out[m] = 1'b0;
                else if (cc == 2'd1) m_out[m] = 1'b1;
                else if (cc == 2'd3) m_out[m] = ~m_out[m];
            end
        end else begin
            m_left[m] = m_left[m] - 1;
            if (!r[m_w[m]] || m_left[m] == 0) begin
                m_act[m] = 1'b0;
                m_ptr[m] = (m_w[m] + 1) % 4;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_n, if0.req, if0.code);
        model_step(1, rst_n, if1.req, if1.code);
    end

    task automatic cmp(input int m, input logic [3:0] g, input logic o, input logic ov, input logic b);
        logic [3:0] eg;
        eg = m_act[m] ? (4'b0001 << m_w[m]) : 4'b0000;
        check($sformatf("u%0d grant", m),     32'(g),  32'(eg));
        check($sformatf("u%0d out", m),       32'(o),  32'(m_out[m]));
        check($sformatf("u%0d out_valid", m), 32'(ov), 32'(m_act[m]));
        check($sformatf("u%0d busy", m),      32'(b),  32'(m_act[m]));
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            cmp(0, if0.grant, if0.out, if0.out_valid, if0.busy);
            cmp(1, if1.grant, if1.out, if1.out_valid, if1.busy);
        end
    end

    logic [3:0] rr_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       rr_out   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n    = 1'b0;
        if0.req  = '0;
        if0.code = '0;
        if1.req  = '0;
        if1.code = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset grant", 32'(if0.grant), 32'h0);
        check("reset out", 32'(if0.out), 32'h0);
        check("reset busy", 32'(if0.busy), 32'h0);
        rst_n = 1'b1;

        // Single request from requester 1 with code SET; code flips to CLR mid-grant.
        if0.code = 8'b00_00_01_00;
        if0.req  = 4'b0010;
        @(negedge clk);
        check("single grant c1", 32'(if0.grant), 32'h2);
        check("single out c1", 32'(if0.out), 32'h1);
        check("single valid c1", 32'(if0.out_valid), 32'h1);
        if0.code = 8'b00_00_00_00;
        @(negedge clk);
        check("single grant c2", 32'(if0.grant), 32'h2);
        check("code change out c2", 32'(if0.out), 32'h1);
        @(negedge clk);
        check("single grant c3", 32'(if0.grant), 32'h2);
        check("code change out c3", 32'(if0.out), 32'h1);
        @(negedge clk);
        check("single gap grant", 32'(if0.grant), 32'h0);
        check("single gap out", 32'(if0.out), 32'h1);
        check("single gap busy", 32'(if0.busy), 32'h0);
        if0.req = 4'b0000;
        @(negedge clk);
        check("idle grant", 32'(if0.grant), 32'h0);

        // Reset in the middle of a grant, then fairness from requester 0.
        if0.code = 8'b01_01_01_01;
        if0.req  = 4'b1111;
        @(negedge clk);
        check("pre-reset grant", 32'(if0.grant), 32'h4);
        check("pre-reset out", 32'(if0.out), 32'h1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid reset grant", 32'(if0.grant), 32'h0);
        check("mid reset out", 32'(if0.out), 32'h0);
        check("mid reset valid", 32'(if0.out_valid), 32'h0);
        check("mid reset busy", 32'(if0.busy), 32'h0);
        if0.code = 8'b11_10_01_00;
        rst_n    = 1'b1;
        for (int g = 0; g < 5; g++) begin
            repeat (3) begin
                @(negedge clk);
                check($sformatf("rr grant %0d", g), 32'(if0.grant), 32'(rr_grant[g]));
                check($sformatf("rr out %0d", g), 32'(if0.out), 32'(rr_out[g]));
            end
            @(negedge clk);
            check($sformatf("rr gap %0d", g), 32'(if0.grant), 32'h0);
        end
        if0.req = 4'b0000;
        @(negedge clk);

        // Abort: requester 2 drops its request in its second grant cycle.
        if0.req = 4'b0100;
        @(negedge clk);
        check("abort grant c1", 32'(if0.grant), 32'h4);
        @(negedge clk);
        check("abort grant c2", 32'(if0.grant), 32'h4);
        if0.req = 4'b0000;
        @(negedge clk);
        check("abort release", 32'(if0.grant), 32'h0);
        if0.req = 4'b0101;
        @(negedge clk);
        check("after abort winner", 32'(if0.grant), 32'h1);
        if0.req = 4'b0000;
        repeat (3) @(negedge clk);

        // HOLD=1 instance: requester 3 with toggle code, continuous request.
        if1.code = 8'b11_00_00_00;
        if1.req  = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                check($sformatf("hold1 grant %0d", k), 32'(if1.grant), 32'h8);
                check($sformatf("hold1 out %0d", k), 32'(if1.out), 32'((k / 2) % 2 == 0));
            end else begin
                check($sformatf("hold1 gap %0d", k), 32'(if1.grant), 32'h0);
            end
        end
        if1.req = 4'b0000;
        @(negedge clk);

        // Random traffic on both instances with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) if0.req = 4'($urandom);
            if ($urandom_range(0, 2) == 0) if0.code = 8'($urandom);
            if ($urandom_range(0, 3) == 0) if1.req = 4'($urandom);
            if ($urandom_range(0, 2) == 0) if1.code = 8'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
